// File: rtl/fifo_ctrl_pkg.sv
// Shared write/read-side FIFO control types and helpers.
// Holds FSM encoding, a clog2 helper and default count sizes.
package fifo_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wr_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 8;
  localparam int DEF_TIMEOUT   = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Bits needed to hold 0..max_val without wrap.
  function automatic int cnt_w(input int max_val);
    return clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr.sv
// Rotating-priority picker: first set req after ptr, modulo NUM_REQ.
// Ports: req, ptr in; gnt_id, gnt_any out. Purely combinational.
module rr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDW     = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     gnt_id,
  output logic               gnt_any
);

  int idx;

  // Walk from lowest to highest priority so the
  // nearest requester after ptr overwrites last.
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        gnt_id  = IDW'(idx);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Burst-granular round-robin arbiter for one async_fifo write port.
// Ports: req_valid/last/data in, req_ready out; fifo_wr_en/data out,
// fifo_full/almost_full in; grant_valid/id, burst_done/abort out.
module fifo_write_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int DATA_WIDTH = 16,
  parameter  int MAX_BURST  = DEF_MAX_BURST,
  parameter  int TIMEOUT    = DEF_TIMEOUT,
  localparam int IDW        = clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          grant_valid,
  output logic [IDW-1:0]                grant_id,
  output logic                          burst_done,
  output logic                          burst_abort
);

  localparam int BW = cnt_w(MAX_BURST);
  localparam int SW = cnt_w(TIMEOUT);

  wr_state_e state_q, state_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [SW-1:0]  stall_q, stall_d;
  logic done_q, done_d;
  logic abort_q, abort_d;

  logic [IDW-1:0]        arb_id;
  logic                  arb_any;
  logic                  in_burst;
  logic                  g_valid;
  logic                  g_last;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] g_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_id  (arb_id),
    .gnt_any (arb_any)
  );

  // rst gates the handshake so nothing moves
  // in the cycle the reset is being applied.
  assign in_burst = (state_q == ST_BURST) && !rst;
  assign g_valid  = req_valid[gid_q];
  assign g_last   = req_last[gid_q];
  assign g_data   = req_data[gid_q*DATA_WIDTH +: DATA_WIDTH];
  assign xfer     = in_burst && g_valid && !fifo_full;

  always_comb begin
    req_ready = '0;
    if (in_burst && !fifo_full)
      req_ready[gid_q] = 1'b1;
  end

  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = xfer ? g_data : '0;
  assign grant_valid  = (state_q == ST_BURST);
  assign grant_id     = gid_q;
  assign burst_done   = done_q;
  assign burst_abort  = abort_q;

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any && !fifo_almost_full) begin
          gid_d   = arb_id;
          beat_d  = '0;
          stall_d = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (xfer) begin
          beat_d  = beat_q + BW'(1);
          stall_d = '0;
          if (g_last ||
              beat_q == BW'(MAX_BURST - 1)) begin
            done_d  = 1'b1;
            ptr_d   = gid_q;
            state_d = ST_IDLE;
          end
        end else if (!g_valid) begin
          // Full with valid data holds stall_q;
          // only an empty requester ages out.
          stall_d = stall_q + SW'(1);
          if (stall_q == SW'(TIMEOUT - 1)) begin
            abort_d = 1'b1;
            ptr_d   = gid_q;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gid_q   <= '0;
      ptr_q   <= IDW'(NUM_REQ - 1);
      beat_q  <= '0;
      stall_q <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter with a FIFO occupancy model.
// Inputs change 1 ns after posedge; outputs are sampled at negedge.
module tb_fifo_write_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AFL   = 14;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic            fifo_full = 1'b0;
  logic            fifo_almost_full = 1'b0;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic            burst_done;
  logic            burst_abort;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (8),
    .TIMEOUT    (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_last         (req_last),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .grant_valid      (grant_valid),
    .grant_id         (grant_id),
    .burst_done       (burst_done),
    .burst_abort      (burst_abort)
  );

  typedef logic [16:0] wq_t [$];
  wq_t        rq [NR];
  logic [17:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_wr = 0;
  int n_done = 0;
  int n_abort = 0;
  int abort_cyc = -1;
  int fifo_cnt = 0;
  int first_wr [NR];
  int last_wr [NR];
  logic rst_req = 1'b1;
  logic rd_en = 1'b1;
  logic af_force = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word(input int id, input int s);
    return 16'((id << 12) | s);
  endfunction

  task automatic add(input int id, input int first,
                     input int n, input bit last_end);
    for (int s = first; s < first + n; s++)
      rq[id].push_back({last_end && (s == first + n - 1),
                        word(id, s)});
  endtask

  task automatic exp_push(input int id, input int first,
                          input int n);
    for (int s = first; s < first + n; s++)
      exp_q.push_back({2'(id), word(id, s)});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic clr();
    n_wr = 0;
    n_done = 0;
    n_abort = 0;
    abort_cyc = -1;
    for (int i = 0; i < NR; i++) begin
      first_wr[i] = -1;
      last_wr[i] = -1;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gv"}, grant_valid, 0);
    chk({tag, "_gid"}, grant_id, 0);
    chk({tag, "_done"}, burst_done, 0);
    chk({tag, "_abort"}, burst_abort, 0);
    chk({tag, "_rdy"}, req_ready, 0);
    chk({tag, "_wen"}, fifo_wr_en, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_req = 1'b1;
    tick(2);
    chk_reset(tag);
    rst_req = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    for (int k = 0; k < maxc; k++) begin
      if (exp_q.size() == 0 && !grant_valid) break;
      tick(1);
    end
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_idle"}, grant_valid, 0);
  endtask

  // Drive: requester fronts and FIFO flags.
  always @(posedge clk) begin
    #1;
    rst = rst_req;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = rq[i].size() > 0;
      req_last[i] = (rq[i].size() > 0) ? rq[i][0][16] : 1'b0;
      req_data[i*DW +: DW] = (rq[i].size() > 0) ?
                             rq[i][0][15:0] : '0;
    end
    fifo_full = fifo_cnt >= DEPTH;
    fifo_almost_full = af_force || (fifo_cnt >= AFL);
  end

  // Sample: scoreboard pop on every FIFO write.
  always @(negedge clk) begin
    logic [17:0] e;
    int w;
    int r;
    cyc++;
    w = 0;
    r = 0;
    if (burst_done) n_done++;
    if (burst_abort) begin
      n_abort++;
      abort_cyc = cyc;
    end
    if (fifo_wr_en) begin
      w = 1;
      n_wr++;
      chk("wr_full", fifo_full, 0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      chk("wr_id", grant_id, e[17:16]);
      chk("wr_data", fifo_wr_data, e[15:0]);
      if (first_wr[grant_id] < 0) first_wr[grant_id] = cyc;
      last_wr[grant_id] = cyc;
    end else begin
      chk("wd_zero", fifo_wr_data, 0);
    end
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_ready[i])
        void'(rq[i].pop_front());
    if (rd_en && fifo_cnt > 0) r = 1;
    fifo_cnt = fifo_cnt + w - r;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    tick(2);
    chk_reset("rst0");
    rst_req = 1'b0;
    tick(1);

    // 1: single requester, short burst
    clr();
    add(0, 1, 3, 1'b1);
    exp_push(0, 1, 3);
    wait_idle("t1", 60);
    chk("t1_done", n_done, 1);
    chk("t1_nwr", n_wr, 3);

    // 2: all requesting, full-length bursts rotate
    do_reset("rst2");
    clr();
    add(0, 0, 16, 1'b0);
    for (int i = 1; i < NR; i++) add(i, 0, 8, 1'b0);
    exp_push(0, 0, 8);
    exp_push(1, 0, 8);
    exp_push(2, 0, 8);
    exp_push(3, 0, 8);
    exp_push(0, 8, 8);
    wait_idle("t2", 300);
    chk("t2_done", n_done, 5);
    chk("t2_nwr", n_wr, 40);
    chk("t2_abort", n_abort, 0);

    // 3: granted requester runs dry -> timeout
    clr();
    add(1, 0, 2, 1'b0);
    add(2, 0, 3, 1'b1);
    exp_push(1, 0, 2);
    exp_push(2, 0, 3);
    wait_idle("t3", 120);
    chk("t3_abort", n_abort, 1);
    chk("t3_done", n_done, 1);
    chk("t3_abort_lat", 32'(abort_cyc - last_wr[1]), 17);
    chk("t3_bubble", 32'(first_wr[2] - abort_cyc), 1);

    // 4: FIFO fills, burst stalls, then resumes
    clr();
    rd_en = 1'b0;
    fifo_cnt = 10;
    add(3, 0, 8, 1'b0);
    exp_push(3, 0, 8);
    tick(30);
    chk("t4_stall_nwr", n_wr, 6);
    chk("t4_cnt", fifo_cnt, DEPTH);
    chk("t4_gv", grant_valid, 1);
    chk("t4_gid", grant_id, 3);
    rd_en = 1'b1;
    wait_idle("t4", 120);
    chk("t4_nwr", n_wr, 8);
    chk("t4_done", n_done, 1);

    // 5: almost_full blocks new grants
    clr();
    af_force = 1'b1;
    for (int i = 0; i < NR; i++) add(i, 0, 2, 1'b1);
    for (int i = 0; i < NR; i++) exp_push(i, 0, 2);
    tick(10);
    chk("t5_nogrant", grant_valid, 0);
    chk("t5_nowr", n_wr, 0);
    af_force = 1'b0;
    wait_idle("t5", 120);
    chk("t5_done", n_done, 4);

    // 6: reset mid-burst at beat 4
    clr();
    add(2, 0, 8, 1'b1);
    exp_push(2, 0, 4);
    exp_push(0, 0, 2);
    exp_push(2, 4, 4);
    for (int k = 0; k < 60; k++) begin
      if (n_wr >= 4) break;
      tick(1);
    end
    chk("t6_beats", n_wr, 4);
    rst_req = 1'b1;
    add(0, 0, 2, 1'b1);
    tick(1);
    chk("t6_rst_wen", fifo_wr_en, 0);
    chk("t6_rst_rdy", req_ready, 0);
    rst_req = 1'b0;
    tick(1);
    chk_reset("t6");
    chk("t6_nodone", n_done, 0);
    wait_idle("t6", 120);
    chk("t6_done", n_done, 2);
    chk("t6_abort", n_abort, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
